hazard_stall_unit: RTL

- Stall-side companion to the pipeline forwarding logic. It detects the dependencies that forwarding cannot cover and freezes the front end: it holds PC and IF/ID, and injects a bubble into ID/EX.
- It also sequences a multi-cycle multiply/divide unit with a busy down-counter, and keeps a saturating stall-cycle performance counter.
- It sits beside the ID stage and is driven by ID-stage decode and the ID/EX and EX/MEM pipeline registers.

---
 rtl/hazard_stall_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
//   Sits beside the ID stage and detects the hazards that forwarding cannot
//   resolve. On a stall it holds PC and IF/ID and loads a bubble into ID/EX.
//   It also tracks a multi-cycle mult/div unit with a busy down-counter, and
//   keeps a saturating count of stalled cycles for performance monitoring.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   ID_*                  ID-stage decode: valid, rs/rt fields and usage,
//                         store / branch / muldiv / mfhi-mflo flags
//   ID_EX_* / EX_MEM_*    load flag, GPR write flag, destination register
//   stat_clear            synchronous clear of stall_count
//   PC_Write, IF_ID_Write front-end advance enables (low while stalled)
//   ID_EX_Bubble          ID/EX loads a NOP
//   stall_cause           0 none, 1 load-use, 2 branch-ALU, 3 branch-load(EX),
//                         4 branch-load(MEM), 5 mult/div busy
//   muldiv_busy/start     mult/div busy flag and launch pulse
//   stall_count           saturating stalled-cycle counter
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
   parameter int MULDIV_LATENCY = 4,
   parameter int CNT_W          = 4,
   parameter int STAT_W         = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ID_valid,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic              ID_uses_rs,
   input  logic              ID_uses_rt,
   input  logic              ID_is_store,
   input  logic              ID_is_branch,
   input  logic              ID_is_muldiv,
   input  logic              ID_reads_hilo,
   input  logic              ID_EX_MemRead,
   input  logic              ID_EX_Reg_Write,
   input  logic [4:0]        ID_EX_dest,
   input  logic              EX_MEM_MemRead,
   input  logic [4:0]        EX_MEM_dest,
   input  logic              stat_clear,
   output logic              PC_Write,
   output logic              IF_ID_Write,
   output logic              ID_EX_Bubble,
   output logic [2:0]        stall_cause,
   output logic              muldiv_busy,
   output logic              muldiv_start,
   output logic [STAT_W-1:0] stall_count
);

   localparam logic [2:0] C_NONE     = 3'd0;
   localparam logic [2:0] C_LOAD_USE = 3'd1;
   localparam logic [2:0] C_BR_ALU   = 3'd2;
   localparam logic [2:0] C_BR_LDEX  = 3'd3;
   localparam logic [2:0] C_BR_LDMEM = 3'd4;
   localparam logic [2:0] C_MULDIV   = 3'd5;

   logic [CNT_W-1:0]  r_md_cnt;
   logic [STAT_W-1:0] r_stall_cnt;

   logic       w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
   logic       w_md_busy;
   logic [2:0] w_cause;
   logic       w_stall;
   logic       w_start;

   // $0 is hardwired, so a write to it never creates a dependency.
   assign w_ex_rs  = (ID_EX_dest  != 5'd0) && (ID_EX_dest  == rs);
   assign w_ex_rt  = (ID_EX_dest  != 5'd0) && (ID_EX_dest  == rt);
   assign w_mem_rs = (EX_MEM_dest != 5'd0) && (EX_MEM_dest == rs);
   assign w_mem_rt = (EX_MEM_dest != 5'd0) && (EX_MEM_dest == rt);

   assign w_md_busy = (r_md_cnt != '0);

   // Priority order: muldiv, branch-on-load(EX), branch-on-load(MEM),
   // branch-on-ALU, load-use. A store's rt is data only and is forwarded
   // at MEM, so it is excluded from the load-use rt check.
   always_comb begin
      w_cause = C_NONE;
      if (ID_valid) begin
         if (w_md_busy && (ID_is_muldiv || ID_reads_hilo))
            w_cause = C_MULDIV;
         else if (ID_is_branch && ID_EX_MemRead && (w_ex_rs || w_ex_rt))
            w_cause = C_BR_LDEX;
         else if (ID_is_branch && EX_MEM_MemRead && (w_mem_rs || w_mem_rt))
            w_cause = C_BR_LDMEM;
         else if (ID_is_branch && ID_EX_Reg_Write && !ID_EX_MemRead &&
                  (w_ex_rs || w_ex_rt))
            w_cause = C_BR_ALU;
         else if (ID_EX_MemRead && ((ID_uses_rs && w_ex_rs) ||
                                    (ID_uses_rt && !ID_is_store && w_ex_rt)))
            w_cause = C_LOAD_USE;
      end
   end

   assign w_stall = (w_cause != C_NONE);
   assign w_start = ID_valid && ID_is_muldiv && !w_stall;

   // Outputs are forced to their frozen values while reset is held.
   assign PC_Write     = rst_n && !w_stall;
   assign IF_ID_Write  = rst_n && !w_stall;
   assign ID_EX_Bubble = !rst_n || w_stall;
   assign stall_cause  = rst_n ? w_cause : C_NONE;
   assign muldiv_start = rst_n && w_start;
   assign muldiv_busy  = w_md_busy;
   assign stall_count  = r_stall_cnt;

   // Mult/div busy counter: reload on launch, otherwise count down to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_md_cnt <= '0;
      else if (w_start)
         r_md_cnt <= CNT_W'(MULDIV_LATENCY);
      else if (w_md_busy)
         r_md_cnt <= r_md_cnt - CNT_W'(1);
   end

   // Stall statistics: clear wins over increment; saturate at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_stall_cnt <= '0;
      else if (stat_clear)
         r_stall_cnt <= '0;
      else if (w_stall && (r_stall_cnt != {STAT_W{1'b1}}))
         r_stall_cnt <= r_stall_cnt + STAT_W'(1);
   end

endmodule
